// File: rtl/pwm_sched_pkg.sv
// Shared types and constants for the PWM channel scheduler.
// Holds the run-state encoding, the width helper and the legal parameter bounds.
package pwm_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned PERIOD_MIN = 2;
  localparam int unsigned PERIOD_MAX = 65535;
  localparam int unsigned NCH_MIN    = 1;
  localparam int unsigned NCH_MAX    = 16;

  // Ceiling log2; returns 0 for inputs of 0 or 1.
  function automatic int unsigned pwm_clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/pwm_compare_ch.sv
// One PWM channel: shadow/active duty registers, pending flag, commit and compare.
// The output is registered against the post-commit duty so new duties start cleanly.
module pwm_compare_ch #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr,
  input  logic [CW-1:0] i_duty,
  input  logic          i_commit,
  input  logic          i_idle,
  input  logic [CW-1:0] i_cnt_next,
  input  logic          i_run_next,
  output logic          o_pwm
);

  logic [CW-1:0] r_shadow;
  logic [CW-1:0] r_active;
  logic [CW-1:0] w_active_next;
  logic          r_pending;
  logic          r_pwm;

  // Idle writes bypass the shadow stage; commit and idle writes never coincide.
  always_comb begin
    w_active_next = r_active;
    if (i_idle && i_wr) begin
      w_active_next = i_duty;
    end else if (i_commit && r_pending) begin
      w_active_next = r_shadow;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
      r_pwm     <= 1'b0;
    end else begin
      r_active <= w_active_next;
      if (i_wr) begin
        r_shadow <= i_duty;
      end
      if (i_commit) begin
        r_pending <= 1'b0;
      end else if (i_wr && !i_idle) begin
        r_pending <= 1'b1;
      end
      r_pwm <= i_run_next && (i_cnt_next < w_active_next);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_channel_scheduler.sv
// Bank of NCH PWM outputs driven from one shared period counter.
// Holds the run/drain FSM, the counter and the duty-write handshake decode.
module pwm_channel_scheduler
  import pwm_sched_pkg::*;
#(
  parameter  int NCH    = 4,
  parameter  int PERIOD = 10,
  localparam int CW     = pwm_clog2(PERIOD + 1),
  localparam int CHW    = (NCH > 1) ? pwm_clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           stop,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [CHW-1:0] cfg_ch,
  input  logic [CW-1:0]  cfg_duty,
  output logic [NCH-1:0] pwm_out,
  output logic           period_tick,
  output logic           busy
);

  if ((PERIOD < PERIOD_MIN) || (PERIOD > PERIOD_MAX) ||
      (NCH < NCH_MIN) || (NCH > NCH_MAX)) begin : g_bad_params
    $error("pwm_channel_scheduler: NCH or PERIOD out of range");
  end

  state_e        r_state;
  state_e        w_state_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_next;
  logic          w_last;
  logic          w_running;
  logic          w_tick;
  logic          w_run_next;
  logic          w_accept;
  logic [NCH-1:0] w_wr;

  assign w_running = (r_state != ST_IDLE);
  assign w_last    = (r_cnt == CW'(PERIOD - 1));
  assign w_tick    = w_running && w_last;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_next = ST_RUN;
      ST_RUN:   if (stop) w_state_next = ST_DRAIN;
      ST_DRAIN: if (w_last) w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_next = '0;
    if (w_running && !w_last) begin
      w_cnt_next = r_cnt + CW'(1);
    end
  end

  assign w_run_next = (w_state_next != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Commit cycle is the only cycle a write is refused.
  assign cfg_ready   = ~w_tick;
  assign w_accept    = cfg_valid && cfg_ready;
  assign period_tick = w_tick;
  assign busy        = w_running;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign w_wr[g] = w_accept && (cfg_ch == CHW'(g));

    pwm_compare_ch #(
      .CW(CW)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr      (w_wr[g]),
      .i_duty    (cfg_duty),
      .i_commit  (w_tick),
      .i_idle    (!w_running),
      .i_cnt_next(w_cnt_next),
      .i_run_next(w_run_next),
      .o_pwm     (pwm_out[g])
    );
  end

endmodule

// File: tb/tb_pwm_channel_scheduler.sv
// Scoreboard bench for pwm_channel_scheduler (NCH=4, PERIOD=10).
// Stimulus queues the expected outputs of each cycle; a negedge monitor pops and compares.
module tb_pwm_channel_scheduler;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_ch;
  logic [3:0] cfg_duty;
  logic [3:0] pwm_out;
  logic       period_tick;
  logic       busy;

  typedef struct {
    string      nm;
    logic [6:0] v;
  } exp_t;

  exp_t q[$];
  int   n_chk;
  int   n_fail;
  int   e_duty[4];

  pwm_channel_scheduler #(
    .NCH   (4),
    .PERIOD(10)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_duty   (cfg_duty),
    .pwm_out    (pwm_out),
    .period_tick(period_tick),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    exp_t       e;
    logic [6:0] got;
    if (q.size() > 0) begin
      e   = q.pop_front();
      got = {pwm_out, period_tick, busy, cfg_ready};
      n_chk++;
      if (got !== e.v) begin
        n_fail++;
        $display("FAIL %s: got pwm=%b tick=%b busy=%b ready=%b, expected pwm=%b tick=%b busy=%b ready=%b",
                 e.nm, got[6:3], got[2], got[1], got[0], e.v[6:3], e.v[2], e.v[1], e.v[0]);
      end
    end
  end

  // Drives one cycle of inputs and queues the outputs expected during that cycle.
  // run/ph describe the DUT state in this cycle: running flag and counter phase.
  task automatic cyc(input bit st, input bit sp, input bit v, input logic [1:0] ch,
                     input logic [3:0] d, input bit rn, input bit run, input int ph,
                     input string nm);
    exp_t       e;
    logic [3:0] p;
    bit         tk;
    start     = st;
    stop      = sp;
    cfg_valid = v;
    cfg_ch    = ch;
    cfg_duty  = d;
    rst_n     = rn;
    for (int i = 0; i < 4; i++) p[i] = run && (ph < e_duty[i]);
    tk   = run && (ph == 9);
    e.nm = nm;
    e.v  = {p, tk, run, ~tk};
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cyc(input string nm);
    cyc(0, 0, 0, 2'd0, 4'd0, 1, 0, 0, nm);
  endtask

  task automatic run_cyc(input int ph, input string nm);
    cyc(0, 0, 0, 2'd0, 4'd0, 1, 1, ph, nm);
  endtask

  task automatic wr_cyc(input logic [1:0] ch, input logic [3:0] d, input bit run,
                        input int ph, input string nm);
    cyc(0, 0, 1, ch, d, 1, run, ph, nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_chk  = 0;
    n_fail = 0;
    for (int i = 0; i < 4; i++) e_duty[i] = 0;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0;
    cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_duty = 4'd0;
    @(posedge clk);
    #1;

    cyc(0, 0, 0, 2'd0, 4'd0, 0, 0, 0, "reset_a");
    cyc(0, 0, 0, 2'd0, 4'd0, 0, 0, 0, "reset_b");

    // No duties programmed: outputs stay low, tick every 10 clocks; stop at cnt=4.
    cyc(1, 0, 0, 2'd0, 4'd0, 1, 0, 0, "start_nocfg");
    for (int k = 0; k < 20; k++) run_cyc(k % 10, "run_nocfg");
    for (int k = 0; k < 4; k++) run_cyc(k, "run_prestop");
    cyc(0, 1, 0, 2'd0, 4'd0, 1, 1, 4, "stop_at4");
    for (int k = 5; k < 10; k++) run_cyc(k, "drain");
    idle_cyc("idle_after_drain");
    cyc(1'b0, 1'b1, 0, 2'd0, 4'd0, 1, 0, 0, "stop_ignored_idle");

    // Idle write commits immediately; first high cycle one clock after start.
    wr_cyc(2'd0, 4'd3, 0, 0, "idle_wr_ch0");
    e_duty[0] = 3;
    cyc(1, 0, 0, 2'd0, 4'd0, 1, 0, 0, "start_ch0");
    for (int k = 0; k < 20; k++) run_cyc(k % 10, "run_ch0_d3");

    // Mid-period write to ch1 waits for the boundary; tick-cycle write is refused.
    for (int k = 0; k < 4; k++) run_cyc(k, "pre_wr_ch1");
    wr_cyc(2'd1, 4'd7, 1, 4, "wr_ch1_mid");
    cyc(1, 0, 0, 2'd0, 4'd0, 1, 1, 5, "start_ignored_run");
    for (int k = 6; k < 9; k++) run_cyc(k, "ch1_unchanged");
    wr_cyc(2'd3, 4'd5, 1, 9, "wr_on_tick_refused");
    e_duty[1] = 7;
    for (int k = 0; k < 10; k++) run_cyc(k, "ch1_d7");

    // Two writes to ch2 in one period: last one wins.
    run_cyc(0, "pre_ch2");
    wr_cyc(2'd2, 4'd2, 1, 1, "wr_ch2_first");
    wr_cyc(2'd2, 4'd5, 1, 2, "wr_ch2_second");
    for (int k = 3; k < 10; k++) run_cyc(k, "ch2_pending");
    e_duty[2] = 5;
    for (int k = 0; k < 10; k++) run_cyc(k, "ch2_d5");

    // Boundary duties: 0 -> low, PERIOD and above -> high with no wrap glitch.
    for (int k = 0; k < 3; k++) run_cyc(k, "pre_bounds");
    wr_cyc(2'd0, 4'd0, 1, 3, "wr_ch0_zero");
    run_cyc(4, "pre_bounds");
    wr_cyc(2'd3, 4'd10, 1, 5, "wr_ch3_period");
    wr_cyc(2'd1, 4'd15, 1, 6, "wr_ch1_max");
    for (int k = 7; k < 10; k++) run_cyc(k, "bounds_pending");
    e_duty[0] = 0; e_duty[1] = 15; e_duty[3] = 10;
    for (int k = 0; k < 20; k++) run_cyc(k % 10, "bounds_applied");

    // Reset mid-period clears everything by the next cycle.
    for (int k = 0; k < 6; k++) run_cyc(k, "pre_reset");
    cyc(0, 0, 0, 2'd0, 4'd0, 0, 1, 6, "reset_mid_run");
    for (int i = 0; i < 4; i++) e_duty[i] = 0;
    idle_cyc("after_reset");

    // Start and stop together in idle enters run; cleared duties stay low.
    cyc(1, 1, 0, 2'd0, 4'd0, 1, 0, 0, "start_stop_idle");
    for (int k = 0; k < 10; k++) run_cyc(k, "run_after_reset");
    run_cyc(0, "run_after_reset");
    run_cyc(1, "run_after_reset");
    cyc(0, 1, 0, 2'd0, 4'd0, 1, 1, 2, "stop_at2");
    for (int k = 3; k < 10; k++) run_cyc(k, "drain2");
    idle_cyc("final_idle");

    for (int w = 0; w < 10 && q.size() > 0; w++) @(posedge clk);
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain_queue: %0d entries left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
